// File: rtl/irq_ctrl6502.sv
// irq_ctrl6502 -- memory-mapped interrupt controller for a 6502 core.
//
// Synchronises up to NUM_SRC external IRQ sources and one NMI source.
// Each IRQ source has an enable, an edge/level mode and a polarity setting.
// The controller latches pending state and drives registered irq/nmi levels
// into the core. Software reaches it through an 8-byte register window at
// BASE_ADDR.
//
// Register map (address[2:0]):
//   0 PEND    R: pending bits           W1C: clears edge-mode bits
//   1 ENABLE  R/W
//   2 EDGE    R/W  1 = edge mode, 0 = level mode
//   3 POL     R/W  1 = active-low source
//   4 ACTIVE  R: pend & ENABLE
//   5 PRIO    R: {any_active, 4'b0, lowest active index}
//   6 NMICTL  R: {6'b0, nmi, nmi_pend}  W: bit0 = 1 clears nmi_pend
//   7 SOFT    R: 0                      W1S: sets edge-mode pend bits
//
// Ports:
//   clk      system clock, all state changes on posedge
//   reset_n  asynchronous active-low reset
//   address  CPU address bus
//   write    CPU write strobe
//   data_i   CPU write data
//   data_o   register read data, combinational, 0 when sel is low
//   sel      address falls inside the register window
//   irq_src  asynchronous IRQ sources
//   nmi_src  asynchronous NMI source
//   irq      registered IRQ level to the core
//   nmi      registered NMI level to the core (core edge-detects it)

module irq_ctrl6502 #(
   parameter int          NUM_SRC   = 8,
   parameter logic [15:0] BASE_ADDR = 16'hD000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        address,
   input  logic               write,
   input  logic [7:0]         data_i,
   output logic [7:0]         data_o,
   output logic               sel,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               nmi_src,
   output logic               irq,
   output logic               nmi
);

   localparam logic [2:0] A_PEND   = 3'd0;
   localparam logic [2:0] A_ENABLE = 3'd1;
   localparam logic [2:0] A_EDGE   = 3'd2;
   localparam logic [2:0] A_POL    = 3'd3;
   localparam logic [2:0] A_ACTIVE = 3'd4;
   localparam logic [2:0] A_PRIO   = 3'd5;
   localparam logic [2:0] A_NMICTL = 3'd6;
   localparam logic [2:0] A_SOFT   = 3'd7;

   // IRQ source path and configuration
   logic [NUM_SRC-1:0] irq_s1_q, irq_s1_d;
   logic [NUM_SRC-1:0] irq_s2_q, irq_s2_d;
   logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
   logic [NUM_SRC-1:0] pol_q, pol_d;
   logic               irq_q, irq_d;

   // NMI path
   logic nmi_s1_q, nmi_s1_d;
   logic nmi_s2_q, nmi_s2_d;
   logic nmi_prev_q, nmi_prev_d;
   logic nmi_pend_q, nmi_pend_d;
   logic gap_q, gap_d;
   logic nmi_q, nmi_d;

   // Combinational helpers
   logic               wr_en;
   logic [NUM_SRC-1:0] wr_data;
   logic [NUM_SRC-1:0] norm;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] pend_set;
   logic [NUM_SRC-1:0] pend_clr;
   logic               any_active;
   logic [2:0]         prio_idx;
   logic               nmi_rise;
   logic               nmi_clr;

   // Zero-extend a per-source vector onto the 8-bit data bus; bits at and
   // above NUM_SRC read back as 0.
   function automatic logic [7:0] zext(input logic [NUM_SRC-1:0] v);
      logic [7:0] r;
      r = '0;
      r[NUM_SRC-1:0] = v;
      return r;
   endfunction

   assign irq = irq_q;
   assign nmi = nmi_q;

   always_comb begin
      sel      = (address[15:3] == BASE_ADDR[15:3]);
      wr_en    = sel & write;
      wr_data  = data_i[NUM_SRC-1:0];
      norm     = irq_s2_q ^ pol_q;
      rise     = norm & ~irq_prev_q;
      active   = pend_q & enable_q;
      nmi_rise = nmi_s2_q & ~nmi_prev_q;
   end

   // Lowest-numbered active source wins: scan downward so the last hit is
   // the smallest index.
   always_comb begin
      any_active = |active;
      prio_idx   = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) prio_idx = 3'(i);
      end
   end

   always_comb begin
      irq_s1_d    = irq_src;
      irq_s2_d    = irq_s1_q;
      irq_prev_d  = norm;
      enable_d    = enable_q;
      edge_mode_d = edge_mode_q;
      pol_d       = pol_q;
      pend_set    = rise;
      pend_clr    = '0;
      nmi_clr     = 1'b0;

      if (wr_en) begin
         case (address[2:0])
            A_PEND:   pend_clr    = wr_data;
            A_ENABLE: enable_d    = wr_data;
            A_EDGE:   edge_mode_d = wr_data;
            A_POL:    pol_d       = wr_data;
            A_NMICTL: nmi_clr     = data_i[0];
            A_SOFT:   pend_set    = rise | wr_data;
            default:  ;
         endcase
      end

      // Edge-mode bits: set beats clear. Level-mode bits simply follow the
      // normalised input, so PEND/SOFT writes have no lasting effect there.
      pend_d = (edge_mode_q & (pend_set | (pend_q & ~pend_clr)))
             | (~edge_mode_q & norm);
      irq_d  = |active;

      nmi_s1_d   = nmi_src;
      nmi_s2_d   = nmi_s1_q;
      nmi_prev_d = nmi_s2_q;
      nmi_pend_d = nmi_rise | (nmi_pend_q & ~nmi_clr);
      // A fresh edge racing a clear keeps nmi_pend set; the one-cycle gap
      // drops nmi so the core's edge detector sees a new rising edge.
      gap_d      = nmi_rise & nmi_clr;
      nmi_d      = nmi_pend_q & ~gap_q;
   end

   always_comb begin
      data_o = 8'h00;
      if (sel) begin
         case (address[2:0])
            A_PEND:   data_o = zext(pend_q);
            A_ENABLE: data_o = zext(enable_q);
            A_EDGE:   data_o = zext(edge_mode_q);
            A_POL:    data_o = zext(pol_q);
            A_ACTIVE: data_o = zext(active);
            A_PRIO:   data_o = any_active ? {1'b1, 4'b0, prio_idx} : 8'h00;
            A_NMICTL: data_o = {6'b0, nmi_q, nmi_pend_q};
            A_SOFT:   data_o = 8'h00;
            default:  data_o = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_s1_q    <= '0;
         irq_s2_q    <= '0;
         irq_prev_q  <= '0;
         pend_q      <= '0;
         enable_q    <= '0;
         edge_mode_q <= '0;
         pol_q       <= '0;
         irq_q       <= 1'b0;
         nmi_s1_q    <= 1'b0;
         nmi_s2_q    <= 1'b0;
         nmi_prev_q  <= 1'b0;
         nmi_pend_q  <= 1'b0;
         gap_q       <= 1'b0;
         nmi_q       <= 1'b0;
      end else begin
         irq_s1_q    <= irq_s1_d;
         irq_s2_q    <= irq_s2_d;
         irq_prev_q  <= irq_prev_d;
         pend_q      <= pend_d;
         enable_q    <= enable_d;
         edge_mode_q <= edge_mode_d;
         pol_q       <= pol_d;
         irq_q       <= irq_d;
         nmi_s1_q    <= nmi_s1_d;
         nmi_s2_q    <= nmi_s2_d;
         nmi_prev_q  <= nmi_prev_d;
         nmi_pend_q  <= nmi_pend_d;
         gap_q       <= gap_d;
         nmi_q       <= nmi_d;
      end
   end

endmodule

// File: tb/tb_irq_ctrl6502.sv
// Testbench for irq_ctrl6502: directed scenarios plus a randomized run
// against a history-based reference model of the pending/irq behaviour.
module tb_irq_ctrl6502;

   localparam logic [15:0] BASE = 16'hD000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] address;
   logic        write;
   logic [7:0]  data_i;
   logic [7:0]  data_o;
   logic        sel;
   logic [7:0]  irq_src;
   logic        nmi_src;
   logic        irq;
   logic        nmi;

   int checks   = 0;
   int failures = 0;

   irq_ctrl6502 #(.NUM_SRC(8), .BASE_ADDR(16'hD000)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .address (address),
      .write   (write),
      .data_i  (data_i),
      .data_o  (data_o),
      .sel     (sel),
      .irq_src (irq_src),
      .nmi_src (nmi_src),
      .irq     (irq),
      .nmi     (nmi)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      irq_src = 8'h00;
      nmi_src = 1'b0;
      address = 16'h0000;
      write   = 1'b0;
      data_i  = 8'h00;
      repeat (2) step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
      address = BASE + {13'd0, off};
      write   = 1'b1;
      data_i  = d;
      step();
      write   = 1'b0;
      data_i  = 8'h00;
   endtask

   function automatic logic [7:0] exp_prio(input logic [7:0] a);
      for (int i = 0; i < 8; i++) begin
         if (a[i]) return {1'b1, 4'b0, 3'(i)};
      end
      return 8'h00;
   endfunction

   task automatic test_reset();
      logic [15:0] outside [4] = '{16'hD008, 16'hCFFF, 16'h5000, 16'hD00F};
      do_reset();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL reset_nmi got=%b exp=0", nmi); end
      for (int i = 0; i < 8; i++) begin
         address = BASE + 16'(i);
         step();
         checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_read off=%0d got=%h exp=00", i, data_o); end
         checks++; if (sel !== 1'b1) begin failures++; $display("FAIL reset_sel_in addr=%h got=%b exp=1", address, sel); end
      end
      for (int i = 0; i < 4; i++) begin
         address = outside[i];
         step();
         checks++; if (sel !== 1'b0) begin failures++; $display("FAIL sel_out addr=%h got=%b exp=0", address, sel); end
         checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL data_out_unsel addr=%h got=%h exp=00", address, data_o); end
      end
   endtask

   task automatic test_edge_irq();
      do_reset();
      bus_write(3'd1, 8'h04);
      bus_write(3'd2, 8'h04);
      irq_src = 8'h04;
      step();                      // posedge 0
      irq_src = 8'h00;
      step();                      // posedge 1
      step();                      // posedge 2
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_p2 got=%b exp=0", irq); end
      step();                      // posedge 3
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_p3 got=%b exp=1", irq); end
      address = BASE + 16'd0; #1;
      checks++; if (data_o !== 8'h04) begin failures++; $display("FAIL edge_pend got=%h exp=04", data_o); end
      address = BASE + 16'd5; #1;
      checks++; if (data_o !== 8'h82) begin failures++; $display("FAIL edge_prio got=%h exp=82", data_o); end
      bus_write(3'd0, 8'h04);      // W1C at posedge k
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL w1c_irq_k got=%b exp=1", irq); end
      step();                      // posedge k+1
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_k1 got=%b exp=0", irq); end
      address = BASE + 16'd0; #1;
      checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL w1c_pend got=%h exp=00", data_o); end
   endtask

   task automatic test_level();
      do_reset();
      irq_src = 8'h01;
      bus_write(3'd3, 8'h01);
      repeat (4) step();
      bus_write(3'd1, 8'h01);
      step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_idle got=%b exp=0", irq); end
      irq_src = 8'h00;             // active-low source asserts
      step(); step(); step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_on_p2 got=%b exp=0", irq); end
      step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_on_p3 got=%b exp=1", irq); end
      bus_write(3'd0, 8'h01);
      step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_w1c_irq got=%b exp=1", irq); end
      address = BASE + 16'd0; #1;
      checks++; if (data_o !== 8'h01) begin failures++; $display("FAIL level_w1c_pend got=%h exp=01", data_o); end
      irq_src = 8'h01;             // source deasserts
      step(); step(); step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_off_p2 got=%b exp=1", irq); end
      step();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_off_p3 got=%b exp=0", irq); end
   endtask

   task automatic test_priority();
      do_reset();
      bus_write(3'd1, 8'hFF);
      bus_write(3'd2, 8'hFF);
      bus_write(3'd7, 8'h28);
      address = BASE + 16'd5; #1;
      checks++; if (data_o !== 8'h83) begin failures++; $display("FAIL prio_soft got=%h exp=83", data_o); end
      address = BASE + 16'd4; #1;
      checks++; if (data_o !== 8'h28) begin failures++; $display("FAIL active_soft got=%h exp=28", data_o); end
      address = BASE + 16'd7; #1;
      checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL soft_read got=%h exp=00", data_o); end
      step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL prio_irq got=%b exp=1", irq); end
      bus_write(3'd0, 8'h08);
      address = BASE + 16'd5; #1;
      checks++; if (data_o !== 8'h85) begin failures++; $display("FAIL prio_after_clr got=%h exp=85", data_o); end
      address = BASE + 16'd0; #1;
      checks++; if (data_o !== 8'h20) begin failures++; $display("FAIL pend_after_clr got=%h exp=20", data_o); end
   endtask

   task automatic test_nmi();
      do_reset();
      nmi_src = 1'b1;
      step(); step(); step();
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_p2 got=%b exp=0", nmi); end
      step();
      checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_p3 got=%b exp=1", nmi); end
      address = BASE + 16'd6; #1;
      checks++; if (data_o !== 8'h03) begin failures++; $display("FAIL nmictl_set got=%h exp=03", data_o); end
      nmi_src = 1'b0;
      repeat (3) step();
      nmi_src = 1'b1;
      step();                      // posedge 0
      step();                      // posedge 1: synced rise now visible
      address = BASE + 16'd6;
      write   = 1'b1;
      data_i  = 8'h01;
      step();                      // posedge 2: clear coincides with edge
      write   = 1'b0;
      data_i  = 8'h00;
      checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_race_k got=%b exp=1", nmi); end
      checks++; if (data_o !== 8'h03) begin failures++; $display("FAIL nmictl_race_k got=%h exp=03", data_o); end
      step();
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_gap got=%b exp=0", nmi); end
      checks++; if (data_o !== 8'h01) begin failures++; $display("FAIL nmictl_gap got=%h exp=01", data_o); end
      step();
      checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_after_gap got=%b exp=1", nmi); end
      checks++; if (data_o !== 8'h03) begin failures++; $display("FAIL nmictl_after_gap got=%h exp=03", data_o); end
      bus_write(3'd6, 8'h01);
      step();
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_clear got=%b exp=0", nmi); end
      checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL nmictl_clear got=%h exp=00", data_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus_write(3'd1, 8'h01);
      bus_write(3'd2, 8'h01);
      nmi_src = 1'b1;
      bus_write(3'd7, 8'h01);
      repeat (4) step();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
      checks++; if (nmi !== 1'b1) begin failures++; $display("FAIL pre_reset_nmi got=%b exp=1", nmi); end
      address = BASE + 16'd1;
      #2;
      reset_n = 1'b0;              // mid-cycle, no clock edge involved
      #1;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%b exp=0", irq); end
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL async_nmi got=%b exp=0", nmi); end
      for (int i = 0; i < 8; i++) begin
         address = BASE + 16'(i);
         #1;
         checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL async_reg off=%0d got=%h exp=00", i, data_o); end
      end
      nmi_src = 1'b0;
      step();
      reset_n = 1'b1;
      step();
   endtask

   // Randomized run. The model keeps a history of raw source samples; the
   // value the controller acts on after posedge n is the sample taken two
   // edges earlier, normalised by polarity.
   task automatic test_random();
      logic [7:0] hist [0:255];
      logic [7:0] en, edg, pol, wdat, norm_a, norm_b, rise, clr, m_pend, m_act, expv;
      logic       m_irq, wr;
      logic [2:0] ra;
      for (int cfg = 0; cfg < 3; cfg++) begin
         do_reset();
         en  = 8'($urandom);
         edg = 8'($urandom);
         pol = 8'($urandom);
         irq_src = pol;            // every source idle
         bus_write(3'd1, en);
         bus_write(3'd2, edg);
         bus_write(3'd3, pol);
         repeat (5) step();
         bus_write(3'd0, 8'hFF);
         repeat (2) step();
         m_pend = 8'h00;
         for (int j = 0; j < 3; j++) hist[j] = pol;
         for (int n = 0; n < 200; n++) begin
            hist[n + 3] = 8'($urandom);
            irq_src = hist[n + 3];
            wr   = ($urandom_range(0, 3) == 0);
            wdat = 8'($urandom);
            case ($urandom_range(0, 2))
               0:       ra = 3'd0;
               1:       ra = 3'd4;
               default: ra = 3'd5;
            endcase
            address = BASE + (wr ? 16'd0 : {13'd0, ra});
            write   = wr;
            data_i  = wdat;
            step();
            norm_a = hist[n + 1] ^ pol;
            norm_b = hist[n] ^ pol;
            rise   = norm_a & ~norm_b;
            clr    = wr ? (wdat & edg) : 8'h00;
            m_irq  = |(m_pend & en);
            m_pend = (edg & (rise | (m_pend & ~clr))) | (~edg & norm_a);
            m_act  = m_pend & en;
            case (wr ? 3'd0 : ra)
               3'd0:    expv = m_pend;
               3'd4:    expv = m_act;
               default: expv = exp_prio(m_act);
            endcase
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq cfg=%0d n=%0d got=%b exp=%b", cfg, n, irq, m_irq); end
            checks++; if (data_o !== expv) begin failures++; $display("FAIL rand_read cfg=%0d n=%0d addr=%h got=%h exp=%h", cfg, n, address, data_o, expv); end
         end
         write  = 1'b0;
         data_i = 8'h00;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      irq_src = 8'h00;
      nmi_src = 1'b0;
      address = 16'h0000;
      write   = 1'b0;
      data_i  = 8'h00;
      test_reset();
      test_edge_irq();
      test_level();
      test_priority();
      test_nmi();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
